// File: rtl/fwd_pingpong_packetmem.sv
// Two-bank ping-pong packet buffer between a writer and a forwarder.
// Optional drop counter enabled by defining FWD_PINGPONG_PACKETMEM_DROP_CNT_EN.
module fwd_pingpong_packetmem #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_en,
  input  logic                  wr_done,
  input  logic [31:0]           wr_len,
  output logic                  ready_for_writer,
  input  logic [ADDR_WIDTH-1:0] forwarder_rd_addr,
  input  logic                  forwarder_rd_en,
  output logic [DATA_WIDTH-1:0] forwarder_rd_data,
  input  logic                  forwarder_done,
`ifdef FWD_PINGPONG_PACKETMEM_DROP_CNT_EN
  output logic [31:0]           drop_count,
`endif
  output logic                  ready_for_forwarder,
  output logic [31:0]           len_to_forwarder
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {
    EMPTY = 1'b0,
    READY = 1'b1
  } bank_state_t;

  bank_state_t           r_state [2];
  logic [31:0]           r_len   [2];
  logic                  r_wsel;
  logic                  r_rsel;
  logic [DATA_WIDTH-1:0] r_rd_data;

  logic [DATA_WIDTH-1:0] r_mem0 [DEPTH];
  logic [DATA_WIDTH-1:0] r_mem1 [DEPTH];

  bank_state_t           w_state_nxt [2];
  logic [31:0]           w_len_nxt   [2];
  logic                  w_wsel_nxt;
  logic                  w_rsel_nxt;
  logic                  w_ready_wr;
  logic                  w_ready_fwd;
  logic                  w_wr_commit;
  logic                  w_fwd_release;

  assign w_ready_wr    = (r_state[r_wsel] == EMPTY);
  assign w_ready_fwd   = (r_state[r_rsel] == READY);
  assign w_wr_commit   = wr_done && w_ready_wr && (wr_len != '0);
  assign w_fwd_release = forwarder_done && w_ready_fwd;

  assign ready_for_writer    = w_ready_wr;
  assign ready_for_forwarder = w_ready_fwd;
  assign len_to_forwarder    = r_len[r_rsel];
  assign forwarder_rd_data   = r_rd_data;

  // Commit and release always target different banks (EMPTY vs READY), so both apply.
  always_comb begin
    w_state_nxt = r_state;
    w_len_nxt   = r_len;
    w_wsel_nxt  = r_wsel;
    w_rsel_nxt  = r_rsel;
    if (w_wr_commit) begin
      w_state_nxt[r_wsel] = READY;
      w_len_nxt[r_wsel]   = wr_len;
      w_wsel_nxt          = ~r_wsel;
    end
    if (w_fwd_release) begin
      w_state_nxt[r_rsel] = EMPTY;
      w_rsel_nxt          = ~r_rsel;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state[0] <= EMPTY;
      r_state[1] <= EMPTY;
      r_len[0]   <= '0;
      r_len[1]   <= '0;
      r_wsel     <= 1'b0;
      r_rsel     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_len   <= w_len_nxt;
      r_wsel  <= w_wsel_nxt;
      r_rsel  <= w_rsel_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && w_ready_wr && !rst) begin
      if (r_wsel) r_mem1[wr_addr] <= wr_data;
      else        r_mem0[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_data <= '0;
    end else if (forwarder_rd_en) begin
      r_rd_data <= r_rsel ? r_mem1[forwarder_rd_addr] : r_mem0[forwarder_rd_addr];
    end
  end

`ifdef FWD_PINGPONG_PACKETMEM_DROP_CNT_EN
  logic [31:0] r_drop_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop_count <= '0;
    end else if (wr_done && !w_ready_wr && (r_drop_count != '1)) begin
      r_drop_count <= r_drop_count + 32'd1;
    end
  end

  assign drop_count = r_drop_count;
`endif

endmodule

// File: tb/tb_fwd_pingpong_packetmem.sv
// Directed bench for fwd_pingpong_packetmem: bank handoff, reads, drops, reset.
module tb_fwd_pingpong_packetmem;

  localparam int DW = 64;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_en;
  logic          wr_done;
  logic [31:0]   wr_len;
  logic          ready_for_writer;
  logic [AW-1:0] forwarder_rd_addr;
  logic          forwarder_rd_en;
  logic [DW-1:0] forwarder_rd_data;
  logic          forwarder_done;
  logic          ready_for_forwarder;
  logic [31:0]   len_to_forwarder;
`ifdef FWD_PINGPONG_PACKETMEM_DROP_CNT_EN
  logic [31:0]   drop_count;
`endif

  int unsigned nvec = 0;
  int unsigned nerr = 0;

  always #5 clk = ~clk;

  fwd_pingpong_packetmem #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .wr_addr             (wr_addr),
    .wr_data             (wr_data),
    .wr_en               (wr_en),
    .wr_done             (wr_done),
    .wr_len              (wr_len),
    .ready_for_writer    (ready_for_writer),
    .forwarder_rd_addr   (forwarder_rd_addr),
    .forwarder_rd_en     (forwarder_rd_en),
    .forwarder_rd_data   (forwarder_rd_data),
    .forwarder_done      (forwarder_done),
`ifdef FWD_PINGPONG_PACKETMEM_DROP_CNT_EN
    .drop_count          (drop_count),
`endif
    .ready_for_forwarder (ready_for_forwarder),
    .len_to_forwarder    (len_to_forwarder)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs then change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; wr_done = 1'b0; wr_len = '0;
    forwarder_rd_en = 1'b0; forwarder_done = 1'b0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    idle(); wr_en = 1'b1; wr_addr = a; wr_data = d; tick(); idle();
  endtask

  task automatic done(input logic [31:0] len);
    idle(); wr_done = 1'b1; wr_len = len; tick(); idle();
  endtask

  task automatic fdone();
    idle(); forwarder_done = 1'b1; tick(); idle();
  endtask

  task automatic rd(input logic [AW-1:0] a);
    idle(); forwarder_rd_en = 1'b1; forwarder_rd_addr = a; tick(); idle();
  endtask

  initial begin
    rst = 1'b1;
    wr_addr = '0; wr_data = '0; forwarder_rd_addr = '0;
    idle();
    tick(); tick();
    chk("rst_rfw", ready_for_writer, 1);
    chk("rst_rff", ready_for_forwarder, 0);
    chk("rst_len", len_to_forwarder, 0);
    chk("rst_rdata", forwarder_rd_data, 0);
    rst = 1'b0;
    tick();

    // Packet A into bank 0.
    for (int i = 0; i < 4; i++) wr(AW'(i), DW'(8'hA0 + i));
    chk("a_rfw_pre", ready_for_writer, 1);
    chk("a_rff_pre", ready_for_forwarder, 0);
    done(32'd4);
    chk("a_rff", ready_for_forwarder, 1);
    chk("a_len", len_to_forwarder, 4);
    chk("a_rfw", ready_for_writer, 1);

    rd(AW'(2));
    chk("rd_a2", forwarder_rd_data, 64'hA2);
    tick();
    chk("rd_hold", forwarder_rd_data, 64'hA2);
    rd(AW'(0));
    chk("rd_a0", forwarder_rd_data, 64'hA0);

    fdone();
    chk("rel_rff", ready_for_forwarder, 0);
    chk("rel_rfw", ready_for_writer, 1);

    // Zero-length commit and release with no READY bank: no effect.
    done(32'd0);
    chk("z_rfw", ready_for_writer, 1);
    chk("z_rff", ready_for_forwarder, 0);
    fdone();
    chk("nf_rff", ready_for_forwarder, 0);
    chk("nf_rfw", ready_for_writer, 1);

    // Packet B (len 3) into bank 1, including the top address.
    wr(AW'(0), 64'hB0);
    wr(AW'(1), 64'hB1);
    wr(AW'(1023), 64'hB2);
    done(32'd3);
    chk("b_rff", ready_for_forwarder, 1);
    chk("b_len", len_to_forwarder, 3);
    chk("b_rfw", ready_for_writer, 1);

    // Packet C (len 5) into bank 0.
    for (int i = 0; i < 5; i++) wr(AW'(i), DW'(8'hC0 + i));
    done(32'd5);
    chk("full_rfw", ready_for_writer, 0);
    chk("full_len", len_to_forwarder, 3);
    wr(AW'(0), 64'hDEAD);
    done(32'd7);
    chk("drop_rfw", ready_for_writer, 0);
    chk("drop_len", len_to_forwarder, 3);
`ifdef FWD_PINGPONG_PACKETMEM_DROP_CNT_EN
    chk("drop_cnt", drop_count, 1);
`endif
    rd(AW'(1023));
    chk("rd_b_top", forwarder_rd_data, 64'hB2);
    fdone();
    chk("c_len", len_to_forwarder, 5);
    chk("c_rff", ready_for_forwarder, 1);
    chk("c_rfw", ready_for_writer, 1);
    rd(AW'(0));
    chk("rd_c0", forwarder_rd_data, 64'hC0);

    // Simultaneous write/read, then simultaneous commit (bank 1) and release (bank 0).
    idle();
    wr_en = 1'b1; wr_addr = AW'(1); wr_data = 64'hD0;
    forwarder_rd_en = 1'b1; forwarder_rd_addr = AW'(4);
    tick(); idle();
    chk("rw_c4", forwarder_rd_data, 64'hC4);
    idle(); wr_done = 1'b1; wr_len = 32'd2; forwarder_done = 1'b1;
    tick(); idle();
    chk("sim_rff", ready_for_forwarder, 1);
    chk("sim_len", len_to_forwarder, 2);
    chk("sim_rfw", ready_for_writer, 1);
    rd(AW'(1));
    chk("rd_d0", forwarder_rd_data, 64'hD0);

    // Fill bank 0 too, then assert reset asynchronously mid-cycle.
    done(32'd6);
    chk("pre_rst_rfw", ready_for_writer, 0);
    #3 rst = 1'b1;
    #1;
    chk("arst_rfw", ready_for_writer, 1);
    chk("arst_rff", ready_for_forwarder, 0);
    chk("arst_len", len_to_forwarder, 0);
    chk("arst_rdata", forwarder_rd_data, 0);
    tick();
    rst = 1'b0;
    tick();
    done(32'd1);
    chk("post_len", len_to_forwarder, 1);
    chk("post_rff", ready_for_forwarder, 1);
    chk("post_rfw", ready_for_writer, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
